// File: rtl/divmod_pkg.sv
// Shared types and width helpers for the sequential signed/unsigned divider.
// Helpers work on a MAX_W-bit carrier so one package serves any WIDTH/OUT_W up to 64.
package divmod_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    return (MAX_W'(1) << width) - MAX_W'(1);
  endfunction

  function automatic logic msb_w(input logic [MAX_W-1:0] value, input int width);
    return ((value >> (width - 1)) & MAX_W'(1)) != '0;
  endfunction

  // abs(MIN) stays 2^(width-1): the magnitude is always read as unsigned
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value, input int width,
                                             input logic sgn);
    logic [MAX_W-1:0] mag;
    mag = (sgn && msb_w(value, width)) ? (~value + MAX_W'(1)) : value;
    return mag & width_mask(width);
  endfunction

  function automatic logic [MAX_W-1:0] ext_w(input logic [MAX_W-1:0] value, input int width,
                                             input logic sgn);
    if (sgn && msb_w(value, width)) return value | ~width_mask(width);
    return value & width_mask(width);
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring division step: shift in the next dividend bit, trial subtract, keep if non-negative.
module divmod_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so the top bit of diff is a clean borrow
  assign shifted  = {rem, bit_in};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divmod_seq_signed.sv
// Iterative divider: magnitudes are divided one bit per cycle, signs re-applied on entry to DONE.
// Results follow Verilog / and % (truncation toward zero), extended to OUT_W by the request mode.
module divmod_seq_signed
  import divmod_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_quot,
  output logic [OUT_W-1:0] out_rem,
  output logic             out_div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic             mode_q, qneg_q, rneg_q;

  logic             accept, zero_div, a_neg, b_neg, step_q;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nx, q_mag, q_fin, r_fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign zero_div  = (in_divisor == '0);

  assign a_neg = in_signed & in_dividend[WIDTH-1];
  assign b_neg = in_signed & in_divisor[WIDTH-1];
  assign a_mag = WIDTH'(abs_w(MAX_W'(in_dividend), WIDTH, in_signed));
  assign b_mag = WIDTH'(abs_w(MAX_W'(in_divisor), WIDTH, in_signed));

  // dvd_q doubles as the quotient shift register: dividend bits leave the top as quotient bits enter
  divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .q_bit    (step_q)
  );

  assign q_mag = {dvd_q[WIDTH-2:0], step_q};
  assign q_fin = qneg_q ? -q_mag : q_mag;
  assign r_fin = rneg_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = zero_div ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      out_quot <= '0;
      out_rem  <= '0;
      out_div0 <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      dvd_q  <= a_mag;
      dvs_q  <= b_mag;
      rem_q  <= '0;
      mode_q <= in_signed;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      if (zero_div) begin
        out_div0 <= 1'b1;
        out_quot <= OUT_W'(ext_w(width_mask(WIDTH), WIDTH, in_signed));
        out_rem  <= OUT_W'(ext_w(MAX_W'(in_dividend), WIDTH, in_signed));
      end
    end else if (state == CALC) begin
      cnt   <= cnt + 1'b1;
      dvd_q <= q_mag;
      rem_q <= rem_nx;
      // MIN / -1 needs no special case: magnitude 2^(WIDTH-1) un-negated wraps back to MIN
      if (cnt == LAST) begin
        out_div0 <= 1'b0;
        out_quot <= OUT_W'(ext_w(MAX_W'(q_fin), WIDTH, mode_q));
        out_rem  <= OUT_W'(ext_w(MAX_W'(r_fin), WIDTH, mode_q));
      end
    end
  end

endmodule

// File: tb/tb_divmod_seq_signed.sv
// Scoreboard bench for divmod_seq_signed (WIDTH=4, OUT_W=8): directed cases, backpressure,
// mid-operation reset and randomized requests checked against an integer / and % model.
module tb_divmod_seq_signed;

  localparam int W  = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_dividend = '0;
  logic [W-1:0]  in_divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_quot;
  logic [OW-1:0] out_rem;
  logic          out_div0;

  typedef struct {
    logic [OW-1:0] quot;
    logic [OW-1:0] rem;
    logic          div0;
    int            acc;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   last_hs = -1;
  int   last_acc = -1;
  bit   have = 1'b0;
  exp_t cur;

  divmod_seq_signed #(.WIDTH(W), .OUT_W(OW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .out_div0    (out_div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer / and %, with the divide-by-zero and MIN/-1 rules on top
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sb, q, r;
    e.div0 = (b == '0);
    e.lat  = e.div0 ? 1 : W + 1;
    e.acc  = 0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) begin q = -1; r = sa; end
      else if (sa == -(2 ** (W - 1)) && sb == -1) begin q = sa; r = 0; end
      else begin q = sa / sb; r = sa % sb; end
    end else begin
      sa = int'(a);
      sb = int'(b);
      if (sb == 0) begin q = 2 ** W - 1; r = sa; end
      else begin q = sa / sb; r = sa % sb; end
    end
    e.quot = OW'(q);
    e.rem  = OW'(r);
    return e;
  endfunction

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input bit use_exp,
                       input logic [OW-1:0] q, input logic [OW-1:0] r, input logic d0);
    exp_t e;
    int t;
    in_signed   = sgn;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(sgn, a, b);
    if (use_exp) begin
      e.quot = q;
      e.rem  = r;
      e.div0 = d0;
    end
    e.acc    = cyc;
    last_acc = cyc;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (!out_valid && t < n) begin
      @(negedge clk);
      t++;
    end
    check_eq("out_valid_timeout", out_valid, 1);
  endtask

  task automatic drain(input int n);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < n) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_queue_left", exp_q.size(), 0);
  endtask

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (out_valid) begin
        check_eq("busy_in_ready", in_ready, 0);
        if (!have) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_result: got quot %0h rem %0h with no request pending",
                     out_quot, out_rem);
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            check_eq("quot", out_quot, cur.quot);
            check_eq("rem", out_rem, cur.rem);
            check_eq("div0", out_div0, cur.div0);
            check_eq("latency", cyc - cur.acc, cur.lat);
          end
        end else begin
          check_eq("hold_quot", out_quot, cur.quot);
          check_eq("hold_rem", out_rem, cur.rem);
          check_eq("hold_div0", out_div0, cur.div0);
        end
        if (out_ready) begin
          have    = 1'b0;
          last_hs = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic          sgn;
    logic [W-1:0]  a, b;

    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_quot", out_quot, 0);
    check_eq("rst_rem", out_rem, 0);
    check_eq("rst_div0", out_div0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    issue(1'b0, 4'hD, 4'h3, 1, 1, 8'h04, 8'h01, 1'b0);
    issue(1'b1, 4'hD, 4'h2, 1, 1, 8'hFF, 8'hFF, 1'b0);
    issue(1'b0, 4'hD, 4'h2, 1, 1, 8'h06, 8'h01, 1'b0);
    issue(1'b1, 4'h8, 4'hF, 1, 1, 8'hF8, 8'h00, 1'b0);
    issue(1'b1, 4'h0, 4'h2, 1, 1, 8'h00, 8'h00, 1'b0);
    issue(1'b0, 4'h9, 4'h0, 1, 1, 8'h0F, 8'h09, 1'b1);
    issue(1'b1, 4'h9, 4'h0, 1, 1, 8'hFF, 8'hF9, 1'b1);
    issue(1'b0, 4'hF, 4'h1, 1, 1, 8'h0F, 8'h00, 1'b0);
    issue(1'b1, 4'h7, 4'hE, 1, 1, 8'hFD, 8'h01, 1'b0);
    drain(100);

    // Backpressure: result held for 5+ cycles, a second request waits behind it
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #2;
    issue(1'b0, 4'h7, 4'h2, 1, 1, 8'h03, 8'h01, 1'b0);
    @(negedge clk);
    wait_out(20);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
      end
      issue(1'b1, 4'h9, 4'h3, 1, 1, 8'hFE, 8'hFF, 1'b0);
    join
    check_eq("accept_after_handshake", last_acc > last_hs, 1);
    drain(100);

    // Reset while the step counter sits at 2: the request is dropped without a result
    @(posedge clk);
    #1;
    issue(1'b0, 4'hE, 4'h3, 0, 0, '0, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      check_eq("post_rst_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;

    rdy_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = W'($urandom);
      b   = W'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 4'h8; b = 4'hF; end
        default: ;
      endcase
      issue(sgn, a, b, 1, 0, '0, '0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
